// File: rtl/factor_pkg.sv
// Shared types and constants for the factor digit display path.
// Digits on the display are divisor = bit index + FACTOR_BASE.
package factor_pkg;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    SEARCH = 3'd1,
    SHOW   = 3'd2,
    GAP    = 3'd3,
    SEP    = 3'd4,
    EMPTY  = 3'd5
  } seq_state_t;

  localparam int FACTOR_BASE = 2;
  localparam int DIGIT_NONE  = 1;
  localparam int FACTOR_BITS = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that can reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Generic count-to-limit on enable, with synchronous clear.
// o_at_last flags that the current count equals the supplied limit.
module tick_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic         o_at_last
);

  logic [W-1:0] r_count;

  assign o_at_last = (r_count == i_last);

  // Saturates at the limit; the owner leaves the counting state there.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_at_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/factor_digit_sequencer.sv
// Steps through the set bits of the divisibility mask on one digit,
// with blank gaps between divisors and a blank separator between scans.
module factor_digit_sequencer
  import factor_pkg::*;
#(
  parameter int HOLD_TICKS = 1,
  parameter int SEP_TICKS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [FACTOR_BITS-1:0] factors,
  output logic [3:0]             digit,
  output logic                   blank,
  output logic                   scan_start,
  output seq_state_t             o_dbg_state
);

  localparam int CNT_W = cnt_width(max_int(HOLD_TICKS, SEP_TICKS));
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] SEP_LAST  = CNT_W'(SEP_TICKS - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(FACTOR_BITS - 1);

  seq_state_t             r_state;
  logic [FACTOR_BITS-1:0] r_snap;
  logic [2:0]             r_idx;
  logic [3:0]             r_digit;
  logic                   r_blank;
  logic                   r_scan_start;

  logic                   w_changed;
  logic                   w_counting;
  logic                   w_cnt_clr;
  logic                   w_cnt_en;
  logic [CNT_W-1:0]       w_cnt_last_val;
  logic                   w_cnt_at_last;

  // A mask change outranks everything, including a coincident tick.
  assign w_changed      = (r_state != LOAD) && (factors != r_snap);
  assign w_counting     = (r_state == SHOW) || (r_state == SEP);
  assign w_cnt_clr      = !w_counting;
  assign w_cnt_en       = w_counting && tick && !w_changed;
  assign w_cnt_last_val = (r_state == SHOW) ? HOLD_LAST : SEP_LAST;

  tick_counter #(
    .W (CNT_W)
  ) u_tick_counter (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .i_last    (w_cnt_last_val),
    .o_at_last (w_cnt_at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= LOAD;
      r_snap       <= '0;
      r_idx        <= '0;
      r_digit      <= 4'd0;
      r_blank      <= 1'b1;
      r_scan_start <= 1'b0;
    end else begin
      r_scan_start <= 1'b0;
      if (w_changed) begin
        r_state <= LOAD;
      end else begin
        case (r_state)
          LOAD: begin
            r_snap <= factors;
            r_idx  <= '0;
            if (factors == '0) begin
              r_state <= EMPTY;
              r_digit <= 4'(DIGIT_NONE);
              r_blank <= 1'b0;
            end else begin
              r_state      <= SEARCH;
              r_scan_start <= 1'b1;
            end
          end
          SEARCH: begin
            if (r_snap[r_idx]) begin
              r_digit <= 4'(r_idx) + 4'(FACTOR_BASE);
              r_blank <= 1'b0;
              r_state <= SHOW;
            end else if (r_idx == LAST_IDX) begin
              r_blank <= 1'b1;
              r_state <= SEP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
          SHOW: begin
            if (tick && w_cnt_at_last) begin
              r_blank <= 1'b1;
              r_state <= GAP;
            end
          end
          GAP: begin
            if (tick) begin
              if (r_idx == LAST_IDX) begin
                r_state <= SEP;
              end else begin
                r_idx   <= r_idx + 3'd1;
                r_state <= SEARCH;
              end
            end
          end
          SEP: begin
            if (tick && w_cnt_at_last) begin
              r_state <= LOAD;
            end
          end
          EMPTY: begin
            r_digit <= 4'(DIGIT_NONE);
            r_blank <= 1'b0;
          end
          default: begin
            r_state <= LOAD;
          end
        endcase
      end
    end
  end

  assign digit       = r_digit;
  assign blank       = r_blank;
  assign scan_start  = r_scan_start;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_factor_digit_sequencer.sv
// Directed bench for factor_digit_sequencer: default timing instance plus
// a HOLD_TICKS=3 / SEP_TICKS=1 instance, all expectations hand-computed.
module tb_factor_digit_sequencer;
  import factor_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick;
  logic [7:0] factors;
  logic [3:0] digit;
  logic       blank, scan_start;
  seq_state_t st;

  logic       reset3, tick3;
  logic [7:0] factors3;
  logic [3:0] digit3;
  logic       blank3, scan_start3;
  seq_state_t st3;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  factor_digit_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .factors     (factors),
    .digit       (digit),
    .blank       (blank),
    .scan_start  (scan_start),
    .o_dbg_state (st)
  );

  factor_digit_sequencer #(
    .HOLD_TICKS (3),
    .SEP_TICKS  (1)
  ) dut3 (
    .clk         (clk),
    .reset       (reset3),
    .tick        (tick3),
    .factors     (factors3),
    .digit       (digit3),
    .blank       (blank3),
    .scan_start  (scan_start3),
    .o_dbg_state (st3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_show(input string tag, input logic [3:0] dig, input logic blk, input int d);
    chk({tag, "_digit"}, 32'(dig), 32'(d));
    chk({tag, "_blank"}, 32'(blk), 32'd0);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic tk();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic tk3();
    tick3 = 1'b1;
    cyc();
    tick3 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; factors = 8'h17;
    reset3 = 1'b1; tick3 = 1'b0; factors3 = 8'hFF;
    cyc(2);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_blank", 32'(blank), 32'd1);
    chk("rst_scan", 32'(scan_start), 32'd0);
    chk("rst_state", 32'(st), 32'(LOAD));

    // 0x17: divisors 2,3,4,6
    reset = 1'b0;
    cyc();
    chk("scan1", 32'(scan_start), 32'd1);
    chk("scan1_state", 32'(st), 32'(SEARCH));
    cyc();
    chk_show("d2", digit, blank, 2);
    chk("scan1_off", 32'(scan_start), 32'd0);
    cyc(5);
    chk_show("d2_hold", digit, blank, 2);
    tk();
    chk("gap2_blank", 32'(blank), 32'd1);
    chk("gap2_digit", 32'(digit), 32'd2);
    chk("gap2_state", 32'(st), 32'(GAP));
    cyc(7);
    tk();
    chk("srch_d3", 32'(st), 32'(SEARCH));
    cyc();
    chk_show("d3", digit, blank, 3);
    tk();
    chk("gap3", 32'(blank), 32'd1);
    tk();
    cyc();
    chk_show("d4", digit, blank, 4);
    tk();
    tk();
    cyc();
    chk("skip5_blank", 32'(blank), 32'd1);
    chk("skip5_state", 32'(st), 32'(SEARCH));
    cyc();
    chk_show("d6", digit, blank, 6);
    tk();
    tk();
    cyc(2);
    chk("srch_tail", 32'(st), 32'(SEARCH));
    cyc();
    chk("sep_state", 32'(st), 32'(SEP));
    chk("sep_blank", 32'(blank), 32'd1);
    tk();
    chk("sep1", 32'(st), 32'(SEP));
    tk();
    chk("sep_end", 32'(st), 32'(LOAD));
    cyc();
    chk("scan2", 32'(scan_start), 32'd1);
    cyc();
    chk_show("scan2_d2", digit, blank, 2);
    tk();
    tk();
    cyc();
    chk_show("scan2_d3", digit, blank, 3);

    // mask change together with a tick: abort wins
    factors = 8'h02; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("abort_state", 32'(st), 32'(LOAD));
    chk_show("abort_hold", digit, blank, 3);
    chk("abort_scan0", 32'(scan_start), 32'd0);
    cyc();
    chk("abort_scan", 32'(scan_start), 32'd1);
    cyc();
    chk("abort_srch", 32'(st), 32'(SEARCH));
    cyc();
    chk_show("abort_d3", digit, blank, 3);
    tk();
    tk();
    cyc(5);
    chk("abort_tail", 32'(st), 32'(SEARCH));
    cyc();
    chk("abort_sep", 32'(st), 32'(SEP));

    // empty mask shows "1" until the mask changes
    factors = 8'h00;
    cyc();
    chk("empty_load", 32'(st), 32'(LOAD));
    cyc();
    chk("empty_state", 32'(st), 32'(EMPTY));
    chk_show("empty", digit, blank, 1);
    chk("empty_scan", 32'(scan_start), 32'd0);
    cyc(10);
    tk();
    cyc(10);
    chk("empty_stay", 32'(st), 32'(EMPTY));
    chk_show("empty_hold", digit, blank, 1);
    factors = 8'h01;
    cyc();
    chk("exit_load", 32'(st), 32'(LOAD));
    chk_show("exit_hold", digit, blank, 1);
    cyc();
    chk("exit_scan", 32'(scan_start), 32'd1);
    cyc();
    chk_show("exit_d2", digit, blank, 2);

    // 0x80: full search before 9, gap straight to separator
    factors = 8'h80;
    cyc();
    chk("d9_load", 32'(st), 32'(LOAD));
    cyc();
    chk("d9_scan", 32'(scan_start), 32'd1);
    cyc(7);
    chk("d9_srch", 32'(st), 32'(SEARCH));
    cyc();
    chk_show("d9", digit, blank, 9);
    tk();
    chk("d9_gap", 32'(st), 32'(GAP));
    chk("d9_gap_blank", 32'(blank), 32'd1);
    tk();
    chk("d9_sep", 32'(st), 32'(SEP));
    tk();
    chk("d9_sep1", 32'(st), 32'(SEP));
    tk();
    chk("d9_reload", 32'(st), 32'(LOAD));
    cyc();
    chk("d9_scan2", 32'(scan_start), 32'd1);
    cyc(8);
    chk_show("d9_again", digit, blank, 9);

    // reset in SHOW, then in SEP
    reset = 1'b1; tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("rshow_digit", 32'(digit), 32'd0);
    chk("rshow_blank", 32'(blank), 32'd1);
    chk("rshow_scan", 32'(scan_start), 32'd0);
    chk("rshow_state", 32'(st), 32'(LOAD));
    reset = 1'b0;
    cyc();
    chk("rshow_rescan", 32'(scan_start), 32'd1);
    cyc(8);
    chk_show("rshow_d9", digit, blank, 9);
    tk();
    tk();
    chk("rsep_pre", 32'(st), 32'(SEP));
    reset = 1'b1;
    cyc();
    chk("rsep_digit", 32'(digit), 32'd0);
    chk("rsep_blank", 32'(blank), 32'd1);
    chk("rsep_scan", 32'(scan_start), 32'd0);
    chk("rsep_state", 32'(st), 32'(LOAD));
    reset = 1'b0;
    cyc();
    chk("rsep_rescan", 32'(scan_start), 32'd1);
    cyc(8);
    chk_show("rsep_d9", digit, blank, 9);

    // HOLD_TICKS=3, SEP_TICKS=1 with every divisor set
    reset3 = 1'b0;
    cyc();
    chk("h3_scan", 32'(scan_start3), 32'd1);
    cyc();
    for (int d = 2; d <= 9; d++) begin
      chk_show($sformatf("h3_d%0d_t0", d), digit3, blank3, d);
      tk3();
      chk_show($sformatf("h3_d%0d_t1", d), digit3, blank3, d);
      tk3();
      chk_show($sformatf("h3_d%0d_t2", d), digit3, blank3, d);
      tk3();
      chk($sformatf("h3_gap%0d", d), 32'(st3), 32'(GAP));
      chk($sformatf("h3_gap%0d_blank", d), 32'(blank3), 32'd1);
      tk3();
      if (d < 9) begin
        chk($sformatf("h3_srch%0d", d), 32'(st3), 32'(SEARCH));
        cyc();
      end
    end
    chk("h3_sep", 32'(st3), 32'(SEP));
    tk3();
    chk("h3_reload", 32'(st3), 32'(LOAD));
    cyc();
    chk("h3_scan2", 32'(scan_start3), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
